// File: rtl/cnn_sequencer_if.sv
// Request/response bundle between the SPI control unit, the CNN core and the sequencer.
// The master side drives requests and CNN results; the slave side is the sequencer.
interface cnn_sequencer_if #(
    parameter int DATAWIDTH_BUS = 8,
    parameter int ADDRESS_WIDTH = 16,
    parameter int PRED_WIDTH    = 4
) ();
    logic                     CNN_Sequencer_Data_Ready;
    logic                     CNN_Sequencer_Is_Weight;
    logic [DATAWIDTH_BUS-1:0] CNN_Sequencer_Weight_InBUS;
    logic [ADDRESS_WIDTH-1:0] CNN_Sequencer_Addr_InBUS;
    logic                     CNN_Sequencer_Done;
    logic [PRED_WIDTH-1:0]    CNN_Sequencer_Prediction_InBUS;
    logic                     CNN_Sequencer_Start;
    logic [DATAWIDTH_BUS-1:0] CNN_Sequencer_Weight_OutBUS;
    logic [ADDRESS_WIDTH-1:0] CNN_Sequencer_Addr_OutBUS;
    logic                     CNN_Sequencer_LoadWeight_InLow;
    logic [PRED_WIDTH-1:0]    CNN_Sequencer_Prediction_OutBUS;
    logic                     CNN_Sequencer_Result_Valid;
    logic                     CNN_Sequencer_Busy;
    logic                     CNN_Sequencer_Overflow;
    logic                     CNN_Sequencer_Timeout;

    modport master (
        output CNN_Sequencer_Data_Ready, CNN_Sequencer_Is_Weight, CNN_Sequencer_Weight_InBUS,
               CNN_Sequencer_Addr_InBUS, CNN_Sequencer_Done, CNN_Sequencer_Prediction_InBUS,
        input  CNN_Sequencer_Start, CNN_Sequencer_Weight_OutBUS, CNN_Sequencer_Addr_OutBUS,
               CNN_Sequencer_LoadWeight_InLow, CNN_Sequencer_Prediction_OutBUS,
               CNN_Sequencer_Result_Valid, CNN_Sequencer_Busy, CNN_Sequencer_Overflow,
               CNN_Sequencer_Timeout
    );

    modport slave (
        input  CNN_Sequencer_Data_Ready, CNN_Sequencer_Is_Weight, CNN_Sequencer_Weight_InBUS,
               CNN_Sequencer_Addr_InBUS, CNN_Sequencer_Done, CNN_Sequencer_Prediction_InBUS,
        output CNN_Sequencer_Start, CNN_Sequencer_Weight_OutBUS, CNN_Sequencer_Addr_OutBUS,
               CNN_Sequencer_LoadWeight_InLow, CNN_Sequencer_Prediction_OutBUS,
               CNN_Sequencer_Result_Valid, CNN_Sequencer_Busy, CNN_Sequencer_Overflow,
               CNN_Sequencer_Timeout
    );
endinterface

// File: rtl/cnn_sequencer.sv
// Sequences weight writes and inference runs for a CNN core: queues weight writes,
// merges image requests, starts inference and supervises it with a timeout.
module cnn_sequencer #(
    parameter int DATAWIDTH_BUS  = 8,
    parameter int ADDRESS_WIDTH  = 16,
    parameter int FIFO_DEPTH     = 4,
    parameter int PRED_WIDTH     = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic           CNN_Sequencer_CLOCK_50,
    input  logic           CNN_Sequencer_RESET_InHigh,
    cnn_sequencer_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int EW = ADDRESS_WIDTH + DATAWIDTH_BUS;
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, WLOAD, START, RUN} state_t;

    logic clk;
    logic rst;
    assign clk = CNN_Sequencer_CLOCK_50;
    assign rst = CNN_Sequencer_RESET_InHigh;

    logic [EW-1:0]            mem [FIFO_DEPTH];
    logic [PW-1:0]            wr_ptr;
    logic [PW-1:0]            rd_ptr;
    logic [CW-1:0]            count;
    logic                     pending;
    logic [TW-1:0]            timer;
    state_t                   state;
    logic                     start_q;
    logic                     load_n_q;
    logic [DATAWIDTH_BUS-1:0] weight_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [PRED_WIDTH-1:0]    pred_q;
    logic                     valid_q;
    logic                     overflow_q;
    logic                     timeout_q;

    logic                     push;
    logic                     image_req;
    logic                     empty;
    logic                     full;
    logic                     pop;
    logic                     push_ok;
    logic [ADDRESS_WIDTH-1:0] head_addr;
    logic [DATAWIDTH_BUS-1:0] head_weight;

    assign push      = bus.CNN_Sequencer_Data_Ready & bus.CNN_Sequencer_Is_Weight;
    assign image_req = bus.CNN_Sequencer_Data_Ready & ~bus.CNN_Sequencer_Is_Weight;
    assign empty     = (count == '0);
    assign full      = (count == FULL_COUNT);
    // The queue drains only from IDLE/WLOAD, so weights are frozen while the CNN runs.
    assign pop       = ((state == IDLE) || (state == WLOAD)) && !empty;
    assign push_ok   = push && (!full || pop);
    assign {head_addr, head_weight} = mem[rd_ptr];

    // NOTE: queue storage carries no reset; pointers and count alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= {bus.CNN_Sequencer_Addr_InBUS, bus.CNN_Sequencer_Weight_InBUS};
    end

    // NOTE: all sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (push && full && !pop) overflow_q <= 1'b1;
        end
    end

    // Image requests merge into one flag; it is consumed when IDLE launches an inference.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                     pending <= 1'b0;
        else if (image_req)                          pending <= 1'b1;
        else if ((state == IDLE) && empty && pending) pending <= 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            timer     <= '0;
            start_q   <= 1'b0;
            load_n_q  <= 1'b1;
            weight_q  <= '0;
            addr_q    <= '0;
            pred_q    <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        state    <= WLOAD;
                        load_n_q <= 1'b0;
                        addr_q   <= head_addr;
                        weight_q <= head_weight;
                    end else if (pending) begin
                        state   <= START;
                        start_q <= 1'b1;
                        valid_q <= 1'b0;
                        timer   <= '0;
                    end
                end
                WLOAD: begin
                    if (!empty) begin
                        addr_q   <= head_addr;
                        weight_q <= head_weight;
                    end else begin
                        state    <= IDLE;
                        load_n_q <= 1'b1;
                        addr_q   <= '0;
                        weight_q <= '0;
                    end
                end
                START: begin
                    start_q <= 1'b0;
                    state   <= RUN;
                end
                RUN: begin
                    if (bus.CNN_Sequencer_Done) begin
                        pred_q  <= bus.CNN_Sequencer_Prediction_InBUS;
                        valid_q <= 1'b1;
                        state   <= IDLE;
                    end else if (timer == TIMER_LAST) begin
                        timeout_q <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.CNN_Sequencer_Start            = start_q;
    assign bus.CNN_Sequencer_LoadWeight_InLow = load_n_q;
    assign bus.CNN_Sequencer_Weight_OutBUS    = weight_q;
    assign bus.CNN_Sequencer_Addr_OutBUS      = addr_q;
    assign bus.CNN_Sequencer_Prediction_OutBUS = pred_q;
    assign bus.CNN_Sequencer_Result_Valid     = valid_q;
    assign bus.CNN_Sequencer_Overflow         = overflow_q;
    assign bus.CNN_Sequencer_Timeout          = timeout_q;
    assign bus.CNN_Sequencer_Busy             = (state != IDLE) || !empty || pending;
endmodule
